// File: rtl/regfile_wb_sched_pkg.sv
// Shared encodings for the register-file write-back scheduler.
// Holds the PC select codes, the PC register address and the regfile address width.
package regfile_wb_sched_pkg;

    localparam int RF_AW = 4;

    typedef logic [RF_AW-1:0] rf_addr_t;

    localparam logic [1:0] SEL_PC_INC   = 2'b00;
    localparam logic [1:0] SEL_PC_START = 2'b01;
    localparam logic [1:0] SEL_PC_DP    = 2'b11;

    localparam rf_addr_t PC_ADDR = 4'd15;

endpackage

// File: rtl/regfile_wb_sched_ld_dest_fifo.sv
// Destination-register FIFO for outstanding loads, popped in issue order.
// Full and empty are derived from the occupancy count; pointers wrap modulo DEPTH.
module ld_dest_fifo
    import regfile_wb_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  rf_addr_t      push_addr,
    input  logic          pop,
    output rf_addr_t      head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    rf_addr_t        mem_q [DEPTH];
    rf_addr_t        mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_addr;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and load scoreboard in front of the 16-entry register file.
// Routes ALU results and load returns to the regfile ports and arbitrates PC loads.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 7,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [3:0]      alu_addr,
    input  logic [31:0]     alu_data,
    input  logic            ld_issue,
    output logic            ld_issue_ready,
    input  logic [3:0]      ld_issue_addr,
    input  logic            ld_ret_valid,
    input  logic [31:0]     ld_ret_data,
    input  logic [3:0]      rd_addr_a,
    input  logic [3:0]      rd_addr_b,
    input  logic [3:0]      rd_addr_s,
    input  logic [3:0]      rd_addr_st,
    output logic            hazard,
    input  logic            pc_start,
    input  logic            pc_step,
    output logic [31:0]     w_data1,
    output logic [3:0]      w_addr1,
    output logic            w_en1,
    output logic [31:0]     w_data_ldr,
    output logic [3:0]      w_addr_ldr,
    output logic            w_en_ldr,
    output logic            load_pc,
    output logic [1:0]      sel_pc,
    output logic [PC_W-1:0] dp_pc,
    output logic [CW-1:0]   ld_pending,
    output logic            ret_err
);

    logic [15:0]     busy_q, busy_d;
    logic [31:0]     w_data1_q, w_data1_d;
    rf_addr_t        w_addr1_q, w_addr1_d;
    logic            w_en1_q, w_en1_d;
    logic [31:0]     w_data_ldr_q, w_data_ldr_d;
    rf_addr_t        w_addr_ldr_q, w_addr_ldr_d;
    logic            w_en_ldr_q, w_en_ldr_d;
    logic            load_pc_q, load_pc_d;
    logic [1:0]      sel_pc_q, sel_pc_d;
    logic [PC_W-1:0] dp_pc_q, dp_pc_d;
    logic            ret_err_q, ret_err_d;

    rf_addr_t        fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;

    logic            alu_acc, issue_acc, ret_pop, ret_bad;
    logic            alu_redir, ld_redir;

    assign alu_ready      = !busy_q[alu_addr];
    assign ld_issue_ready = !fifo_full && !busy_q[ld_issue_addr];
    assign hazard         = busy_q[rd_addr_a] | busy_q[rd_addr_b]
                          | busy_q[rd_addr_s] | busy_q[rd_addr_st];

    assign alu_acc   = alu_valid && alu_ready;
    assign issue_acc = ld_issue && ld_issue_ready;
    assign ret_pop   = ld_ret_valid && !fifo_empty;
    assign ret_bad   = ld_ret_valid && fifo_empty;
    // busy[15] blocks the ALU, so these two can never both be set.
    assign alu_redir = alu_acc && (alu_addr == PC_ADDR);
    assign ld_redir  = ret_pop && (fifo_head == PC_ADDR);

    ld_dest_fifo #(.DEPTH(DEPTH)) u_ld_dest_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue_acc),
        .push_addr (ld_issue_addr),
        .pop       (ret_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        busy_d = busy_q;
        if (ret_pop) begin
            busy_d[fifo_head] = 1'b0;
        end
        if (issue_acc) begin
            busy_d[ld_issue_addr] = 1'b1;
        end

        w_en1_d   = 1'b0;
        w_addr1_d = w_addr1_q;
        w_data1_d = w_data1_q;
        if (alu_acc && !alu_redir) begin
            w_en1_d   = 1'b1;
            w_addr1_d = alu_addr;
            w_data1_d = alu_data;
        end

        w_en_ldr_d   = 1'b0;
        w_addr_ldr_d = w_addr_ldr_q;
        w_data_ldr_d = w_data_ldr_q;
        if (ret_pop && !ld_redir) begin
            w_en_ldr_d   = 1'b1;
            w_addr_ldr_d = fifo_head;
            w_data_ldr_d = ld_ret_data;
        end

        load_pc_d = 1'b0;
        sel_pc_d  = sel_pc_q;
        dp_pc_d   = dp_pc_q;
        if (pc_start) begin
            load_pc_d = 1'b1;
            sel_pc_d  = SEL_PC_START;
        end else if (alu_redir) begin
            load_pc_d = 1'b1;
            sel_pc_d  = SEL_PC_DP;
            dp_pc_d   = alu_data[PC_W-1:0];
        end else if (ld_redir) begin
            load_pc_d = 1'b1;
            sel_pc_d  = SEL_PC_DP;
            dp_pc_d   = ld_ret_data[PC_W-1:0];
        end else if (pc_step) begin
            load_pc_d = 1'b1;
            sel_pc_d  = SEL_PC_INC;
        end

        ret_err_d = ret_err_q | ret_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            w_data1_q    <= '0;
            w_addr1_q    <= '0;
            w_en1_q      <= 1'b0;
            w_data_ldr_q <= '0;
            w_addr_ldr_q <= '0;
            w_en_ldr_q   <= 1'b0;
            load_pc_q    <= 1'b0;
            sel_pc_q     <= SEL_PC_INC;
            dp_pc_q      <= '0;
            ret_err_q    <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            w_data1_q    <= w_data1_d;
            w_addr1_q    <= w_addr1_d;
            w_en1_q      <= w_en1_d;
            w_data_ldr_q <= w_data_ldr_d;
            w_addr_ldr_q <= w_addr_ldr_d;
            w_en_ldr_q   <= w_en_ldr_d;
            load_pc_q    <= load_pc_d;
            sel_pc_q     <= sel_pc_d;
            dp_pc_q      <= dp_pc_d;
            ret_err_q    <= ret_err_d;
        end
    end

    assign w_data1    = w_data1_q;
    assign w_addr1    = w_addr1_q;
    assign w_en1      = w_en1_q;
    assign w_data_ldr = w_data_ldr_q;
    assign w_addr_ldr = w_addr_ldr_q;
    assign w_en_ldr   = w_en_ldr_q;
    assign load_pc    = load_pc_q;
    assign sel_pc     = sel_pc_q;
    assign dp_pc      = dp_pc_q;
    assign ld_pending = fifo_count;
    assign ret_err    = ret_err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: a queue-based model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wb_sched;

    logic        clk, rst_n;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_issue, ld_issue_ready;
    logic [3:0]  ld_issue_addr;
    logic        ld_ret_valid;
    logic [31:0] ld_ret_data;
    logic [3:0]  rd_addr_a, rd_addr_b, rd_addr_s, rd_addr_st;
    logic        hazard, pc_start, pc_step;
    logic [31:0] w_data1, w_data_ldr;
    logic [3:0]  w_addr1, w_addr_ldr;
    logic        w_en1, w_en_ldr, load_pc, ret_err;
    logic [1:0]  sel_pc;
    logic [6:0]  dp_pc;
    logic [2:0]  ld_pending;

    int checks = 0;
    int errors = 0;

    regfile_wb_sched #(.DEPTH(4), .PC_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready), .ld_issue_addr(ld_issue_addr),
        .ld_ret_valid(ld_ret_valid), .ld_ret_data(ld_ret_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_s(rd_addr_s), .rd_addr_st(rd_addr_st),
        .hazard(hazard), .pc_start(pc_start), .pc_step(pc_step),
        .w_data1(w_data1), .w_addr1(w_addr1), .w_en1(w_en1),
        .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr), .w_en_ldr(w_en_ldr),
        .load_pc(load_pc), .sel_pc(sel_pc), .dp_pc(dp_pc),
        .ld_pending(ld_pending), .ret_err(ret_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model: the list of outstanding load destinations, oldest first.
    logic [3:0]  mq[$];
    logic        e_en1, e_en_ldr, e_load_pc, e_ret_err;
    logic [3:0]  e_addr1, e_addr_ldr;
    logic [31:0] e_data1, e_data_ldr;
    logic [1:0]  e_sel;
    logic [6:0]  e_dp;

    function automatic bit mbusy(input logic [3:0] r);
        foreach (mq[i]) if (mq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            e_en1 = 0; e_en_ldr = 0; e_load_pc = 0; e_ret_err = 0;
            e_addr1 = 0; e_addr_ldr = 0; e_data1 = 0; e_data_ldr = 0;
            e_sel = 2'b00; e_dp = 0;
        end else begin
            bit acc, iss, pop, redir;
            logic [6:0] rv;
            logic [3:0] hd;
            chk("m_w_en1", 32'(w_en1), 32'(e_en1));
            if (e_en1) begin
                chk("m_w_addr1", 32'(w_addr1), 32'(e_addr1));
                chk("m_w_data1", w_data1, e_data1);
            end
            chk("m_w_en_ldr", 32'(w_en_ldr), 32'(e_en_ldr));
            if (e_en_ldr) begin
                chk("m_w_addr_ldr", 32'(w_addr_ldr), 32'(e_addr_ldr));
                chk("m_w_data_ldr", w_data_ldr, e_data_ldr);
            end
            chk("m_load_pc", 32'(load_pc), 32'(e_load_pc));
            if (e_load_pc) chk("m_sel_pc", 32'(sel_pc), 32'(e_sel));
            if (e_load_pc && e_sel == 2'b11) chk("m_dp_pc", 32'(dp_pc), 32'(e_dp));
            chk("m_ret_err", 32'(ret_err), 32'(e_ret_err));
            chk("m_ld_pending", 32'(ld_pending), mq.size());
            chk("m_alu_ready", 32'(alu_ready), 32'(!mbusy(alu_addr)));
            chk("m_ld_issue_ready", 32'(ld_issue_ready),
                32'(mq.size() < 4 && !mbusy(ld_issue_addr)));
            chk("m_hazard", 32'(hazard), 32'(mbusy(rd_addr_a) || mbusy(rd_addr_b)
                                           || mbusy(rd_addr_s) || mbusy(rd_addr_st)));

            acc = alu_valid && !mbusy(alu_addr);
            iss = ld_issue && mq.size() < 4 && !mbusy(ld_issue_addr);
            pop = ld_ret_valid && mq.size() > 0;
            hd  = pop ? mq[0] : 4'd0;
            e_en1 = acc && alu_addr != 4'd15;
            if (e_en1) begin e_addr1 = alu_addr; e_data1 = alu_data; end
            e_en_ldr = pop && hd != 4'd15;
            if (e_en_ldr) begin e_addr_ldr = hd; e_data_ldr = ld_ret_data; end
            redir = (acc && alu_addr == 4'd15) || (pop && hd == 4'd15);
            rv = (acc && alu_addr == 4'd15) ? alu_data[6:0] : ld_ret_data[6:0];
            e_load_pc = pc_start || redir || pc_step;
            if (pc_start) e_sel = 2'b01;
            else if (redir) begin e_sel = 2'b11; e_dp = rv; end
            else if (pc_step) e_sel = 2'b00;
            if (ld_ret_valid && mq.size() == 0) e_ret_err = 1;
            if (pop) void'(mq.pop_front());
            if (iss) mq.push_back(ld_issue_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; ld_issue = 0; ld_ret_valid = 0; pc_start = 0; pc_step = 0;
    endtask

    initial begin
        rst_n = 0;
        idle();
        alu_addr = 0; alu_data = 0; ld_issue_addr = 0; ld_ret_data = 0;
        rd_addr_a = 0; rd_addr_b = 0; rd_addr_s = 0; rd_addr_st = 0;
        tick(); tick();
        chk("rst_w_en1", 32'(w_en1), 0);
        chk("rst_sel_pc", 32'(sel_pc), 0);
        chk("rst_pending", 32'(ld_pending), 0);
        rst_n = 1;
        tick();

        // Load to R3 blocks an ALU write to R3 until the data returns.
        ld_issue = 1; ld_issue_addr = 3; #1;
        chk("t2_issue_ready", 32'(ld_issue_ready), 1);
        tick();
        ld_issue = 0; alu_valid = 1; alu_addr = 3; alu_data = 32'h55; rd_addr_a = 3; #1;
        chk("t2_alu_ready", 32'(alu_ready), 0);
        chk("t2_hazard", 32'(hazard), 1);
        tick();
        ld_ret_valid = 1; ld_ret_data = 32'hDEADBEEF; #1;
        chk("t2_alu_ready_ret", 32'(alu_ready), 0);
        tick();
        ld_ret_valid = 0;
        chk("t2_w_en_ldr", 32'(w_en_ldr), 1);
        chk("t2_w_addr_ldr", 32'(w_addr_ldr), 3);
        chk("t2_w_data_ldr", w_data_ldr, 32'hDEADBEEF);
        #1;
        chk("t2_alu_ready_after", 32'(alu_ready), 1);
        chk("t2_hazard_after", 32'(hazard), 0);
        tick();
        alu_valid = 0; rd_addr_a = 0;
        chk("t2_w_en1", 32'(w_en1), 1);
        chk("t2_w_addr1", 32'(w_addr1), 3);
        tick();
        chk("t2_w_en1_pulse", 32'(w_en1), 0);

        // Fill the FIFO with R1..R4, then drain it in order.
        for (int i = 1; i <= 4; i++) begin
            ld_issue = 1; ld_issue_addr = 4'(i);
            tick();
        end
        ld_issue_addr = 5; #1;
        chk("t3_full_ready", 32'(ld_issue_ready), 0);
        chk("t3_pending4", 32'(ld_pending), 4);
        ld_issue = 0;
        for (int i = 1; i <= 4; i++) begin
            ld_ret_valid = 1; ld_ret_data = 32'(i * 256);
            tick();
            chk("t3_w_en_ldr", 32'(w_en_ldr), 1);
            chk("t3_w_addr_ldr", 32'(w_addr_ldr), 32'(i));
            chk("t3_pending", 32'(ld_pending), 32'(4 - i));
        end
        ld_ret_valid = 0;
        tick();

        // ALU and load write in the same cycle on both ports.
        ld_issue = 1; ld_issue_addr = 6;
        tick();
        ld_issue = 0;
        alu_valid = 1; alu_addr = 5; alu_data = 32'h11;
        ld_ret_valid = 1; ld_ret_data = 32'h22;
        tick();
        idle();
        chk("t4_w_en1", 32'(w_en1), 1);
        chk("t4_w_addr1", 32'(w_addr1), 5);
        chk("t4_w_data1", w_data1, 32'h11);
        chk("t4_w_en_ldr", 32'(w_en_ldr), 1);
        chk("t4_w_addr_ldr", 32'(w_addr_ldr), 6);
        chk("t4_w_data_ldr", w_data_ldr, 32'h22);

        // ALU redirect outranks pc_step but loses to pc_start.
        alu_valid = 1; alu_addr = 15; alu_data = 32'h1234; pc_step = 1;
        tick();
        chk("t5_load_pc", 32'(load_pc), 1);
        chk("t5_sel_dp", 32'(sel_pc), 32'h3);
        chk("t5_dp_pc", 32'(dp_pc), 32'h34);
        chk("t5_no_w_en1", 32'(w_en1), 0);
        pc_start = 1;
        tick();
        idle();
        chk("t5_sel_start", 32'(sel_pc), 32'h1);
        tick();
        chk("t5_load_pc_off", 32'(load_pc), 0);

        // Reset with two loads outstanding clears everything asynchronously.
        ld_issue = 1; ld_issue_addr = 7;
        tick();
        ld_issue_addr = 8; alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
        tick();
        idle();
        rd_addr_a = 7; ld_issue_addr = 7;
        chk("t1_pending2", 32'(ld_pending), 2);
        chk("t1_w_en1_pre", 32'(w_en1), 1);
        #1;
        chk("t1_hazard_pre", 32'(hazard), 1);
        rst_n = 0;
        #1;
        chk("t1_pending0", 32'(ld_pending), 0);
        chk("t1_w_en1", 32'(w_en1), 0);
        chk("t1_w_en_ldr", 32'(w_en_ldr), 0);
        chk("t1_hazard", 32'(hazard), 0);
        chk("t1_issue_ready", 32'(ld_issue_ready), 1);
        tick(); tick();
        rst_n = 1; rd_addr_a = 0;
        tick();

        // Return with nothing outstanding: sticky error, no write.
        ld_ret_valid = 1; ld_ret_data = 32'hABCD;
        tick();
        ld_ret_valid = 0;
        chk("t6_ret_err", 32'(ret_err), 1);
        chk("t6_no_write", 32'(w_en_ldr), 0);
        tick(); tick(); tick();
        chk("t6_ret_err_held", 32'(ret_err), 1);
        rst_n = 0;
        #1;
        chk("t6_ret_err_rst", 32'(ret_err), 0);
        tick();
        rst_n = 1;
        tick();

        for (int n = 0; n < 600; n++) begin
            alu_valid     = ($urandom_range(0, 99) < 50);
            alu_addr      = 4'($urandom_range(0, 15));
            alu_data      = $urandom;
            ld_issue      = ($urandom_range(0, 99) < 50);
            ld_issue_addr = 4'($urandom_range(0, 15));
            ld_ret_valid  = ($urandom_range(0, 99) < ((mq.size() > 0) ? 45 : 5));
            ld_ret_data   = $urandom;
            pc_start      = ($urandom_range(0, 99) < 10);
            pc_step       = ($urandom_range(0, 99) < 30);
            rd_addr_a     = 4'($urandom_range(0, 15));
            rd_addr_b     = 4'($urandom_range(0, 15));
            rd_addr_s     = 4'($urandom_range(0, 15));
            rd_addr_st    = 4'($urandom_range(0, 15));
            tick();
        end
        idle();
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
